// File: rtl/game_master_fsm_multi.sv
// game_master_fsm_multi: round sequencer for one target and N independent torpedo sprites
module game_master_fsm_multi #(
  parameter int N_TORPEDOES = 2,
  parameter int N_LIVES     = 3,
  parameter int WIN_SCORE   = 5,
  parameter int SCORE_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   key,
  output logic                   sprite_target_write_xy,
  output logic                   sprite_target_write_dxy,
  output logic                   sprite_target_enable_update,
  input  logic                   sprite_target_within_screen,
  output logic [N_TORPEDOES-1:0] sprite_torpedo_write_xy,
  output logic [N_TORPEDOES-1:0] sprite_torpedo_write_dxy,
  output logic [N_TORPEDOES-1:0] sprite_torpedo_enable_update,
  input  logic [N_TORPEDOES-1:0] sprite_torpedo_within_screen,
  input  logic [N_TORPEDOES-1:0] collision,
  output logic                   end_of_game_timer_start,
  input  logic                   end_of_game_timer_running,
  output logic                   game_won,
  output logic [SCORE_WIDTH-1:0] score,
  output logic [3:0]             lives_left
);
  typedef enum logic [2:0] {START, ROUND, PLAY, END_WAIT, END} state_t;
  state_t state;
  logic key_q, fire, hit, escape, win, lose;
  logic [N_TORPEDOES-1:0] launching, busy, pick, retire;
  logic [SCORE_WIDTH-1:0] score_n;
  logic [3:0] lives_n;
  // Launch slot selection, retire/hit/escape detection and next counter values.
  always_comb begin
    fire    = key & ~key_q;
    busy    = launching | sprite_torpedo_enable_update;
    pick    = ~busy & (busy + N_TORPEDOES'(1));
    retire  = sprite_torpedo_enable_update & (collision | ~sprite_torpedo_within_screen);
    hit     = |(sprite_torpedo_enable_update & collision);
    escape  = ~sprite_target_within_screen & ~hit;
    score_n = (hit && score != SCORE_WIDTH'(WIN_SCORE)) ? score + 1'b1 : score;
    lives_n = (escape && lives_left != 4'd0) ? lives_left - 4'd1 : lives_left;
    win     = score_n == SCORE_WIDTH'(WIN_SCORE);
    lose    = lives_n == 4'd0;
  end
  // Game sequencing; every strobe is a registered one-cycle pulse unless set again.
  always_ff @(posedge clk) begin
    if (reset) begin
      state                        <= START;
      key_q                        <= 1'b0;
      launching                    <= '0;
      sprite_target_write_xy       <= 1'b0;
      sprite_target_write_dxy      <= 1'b0;
      sprite_target_enable_update  <= 1'b0;
      sprite_torpedo_write_xy      <= '0;
      sprite_torpedo_write_dxy     <= '0;
      sprite_torpedo_enable_update <= '0;
      end_of_game_timer_start      <= 1'b0;
      game_won                     <= 1'b0;
      score                        <= '0;
      lives_left                   <= 4'(N_LIVES);
    end else begin
      key_q                    <= key;
      sprite_target_write_xy   <= 1'b0;
      sprite_target_write_dxy  <= 1'b0;
      sprite_torpedo_write_xy  <= '0;
      sprite_torpedo_write_dxy <= '0;
      end_of_game_timer_start  <= 1'b0;
      case (state)
        START: begin
          sprite_target_write_xy       <= 1'b1;
          sprite_target_write_dxy      <= 1'b1;
          sprite_torpedo_write_xy      <= '1;
          sprite_torpedo_write_dxy     <= '1;
          sprite_torpedo_enable_update <= '0;
          sprite_target_enable_update  <= 1'b0;
          launching                    <= '0;
          score                        <= '0;
          lives_left                   <= 4'(N_LIVES);
          game_won                     <= 1'b0;
          state                        <= ROUND;
        end
        ROUND: begin
          sprite_target_enable_update <= 1'b1;
          state                       <= PLAY;
        end
        PLAY: begin
          launching                    <= fire ? pick : '0;
          sprite_torpedo_write_xy      <= fire ? pick : '0;
          sprite_torpedo_write_dxy     <= fire ? pick : '0;
          sprite_torpedo_enable_update <= (sprite_torpedo_enable_update & ~retire) | launching;
          sprite_target_write_xy       <= hit | escape;
          sprite_target_write_dxy      <= hit | escape;
          score                        <= score_n;
          lives_left                   <= lives_n;
          if (win || lose) begin
            game_won                     <= win;
            end_of_game_timer_start      <= 1'b1;
            sprite_target_enable_update  <= 1'b0;
            sprite_torpedo_enable_update <= '0;
            sprite_torpedo_write_xy      <= '0;
            sprite_torpedo_write_dxy     <= '0;
            launching                    <= '0;
            state                        <= END_WAIT;
          end
        end
        END_WAIT: state <= END;
        default: state <= end_of_game_timer_running ? END : START;
      endcase
    end
  end
endmodule
